// File: rtl/oled_iic_writer.sv
// rtl/oled_iic_writer.sv - I2C write engine: START, 3 bytes with ACK, STOP per 24-bit word.
// Optional NACK abort and ack_err reporting when IIC_ACK_CHECK_EN is defined.
module oled_iic_writer #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCL_FREQ = 400_000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        write_req,
  input  logic [23:0] write_data,
  output logic        write_done,
  output logic        busy,
  output logic        ack_err,
  output logic        iic_scl,
  inout  wire         iic_sda
);

  // QDIV below 2 is a configuration error and is not supported.
  localparam int QDIV = CLK_FREQ / (4 * SCL_FREQ);
  localparam int QW = ($clog2(QDIV) < 1) ? 1 : $clog2(QDIV);
  localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

`ifdef IIC_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BIT   = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state;
  logic [QW-1:0] qcnt;
  logic [1:0]    quarter;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [23:0]   shreg;
  logic          nack;
  logic          scl;
  logic          sda_low;
  logic          period_end;
  logic          ack_sample;

  assign period_end = (qcnt == QLAST) && (quarter == 2'd3);
  assign ack_sample = (state == S_ACK) && (quarter == 2'd2) && (qcnt == '0);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      qcnt     <= '0;
      quarter  <= 2'd0;
      bit_cnt  <= 3'd7;
      byte_cnt <= 2'd0;
      shreg    <= 24'd0;
      nack     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          qcnt    <= '0;
          quarter <= 2'd0;
          if (write_req) begin
            shreg    <= write_data;
            bit_cnt  <= 3'd7;
            byte_cnt <= 2'd0;
            nack     <= 1'b0;
            state    <= S_START;
          end
        end
        S_DONE: begin
          qcnt    <= '0;
          quarter <= 2'd0;
          state   <= S_IDLE;
        end
        default: begin
          if (qcnt == QLAST) begin
            qcnt    <= '0;
            quarter <= quarter + 2'd1;
          end else begin
            qcnt <= qcnt + 1'b1;
          end
          // Undriven SDA reads as 1 through the bus pull-up: a NACK.
          if (ack_sample && iic_sda !== 1'b0) nack <= 1'b1;
          if (period_end) begin
            case (state)
              S_START: state <= S_BIT;
              S_BIT: begin
                shreg <= {shreg[22:0], 1'b0};
                if (bit_cnt == 3'd0) state <= S_ACK;
                else bit_cnt <= bit_cnt - 3'd1;
              end
              S_ACK: begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd2 || (ACK_CHECK && nack)) begin
                  state <= S_STOP;
                end else begin
                  bit_cnt <= 3'd7;
                  state   <= S_BIT;
                end
              end
              S_STOP:  state <= S_DONE;
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    case (state)
      S_START: begin
        scl     = (quarter != 2'd3);
        sda_low = (quarter != 2'd0);
      end
      S_BIT: begin
        scl     = (quarter == 2'd1) || (quarter == 2'd2);
        sda_low = ~shreg[23];
      end
      S_ACK: begin
        scl = (quarter == 2'd1) || (quarter == 2'd2);
      end
      S_STOP: begin
        scl     = (quarter != 2'd0);
        sda_low = (quarter < 2'd2);
      end
      default: begin
        scl     = 1'b1;
        sda_low = 1'b0;
      end
    endcase
  end

  assign iic_scl    = scl;
  assign iic_sda    = sda_low ? 1'b0 : 1'bz;
  assign busy       = (state != S_IDLE);
  assign write_done = (state == S_DONE);

`ifdef IIC_ACK_CHECK_EN
  assign ack_err = (state == S_DONE) && nack;
`else
  assign ack_err = 1'b0;
`endif

endmodule

// File: tb/tb_oled_iic_writer.sv
// tb/tb_oled_iic_writer.sv - Self-checking bench: bus decoder, ACK/NACK slave, latency model.
module tb_oled_iic_writer;

  localparam int QDIV = 50_000_000 / (4 * 400_000);
  localparam int START_TOK = 256;
  localparam int STOP_TOK  = 257;
`ifdef IIC_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_req = 1'b0;
  logic [23:0] write_data = 24'd0;
  logic        write_done;
  logic        busy;
  logic        ack_err;
  logic        iic_scl;
  wire         sda_bus;
  logic        slave_low = 1'b0;

  assign sda_bus = slave_low ? 1'b0 : 1'bz;
  pullup pu_sda (sda_bus);

  oled_iic_writer dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .write_req (write_req),
    .write_data(write_data),
    .write_done(write_done),
    .busy      (busy),
    .ack_err   (ack_err),
    .iic_scl   (iic_scl),
    .iic_sda   (sda_bus)
  );

  always #10 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bus decoder plus a slave that ACKs unless told to NACK a byte index.
  int   mon_q[$];
  bit   nack_cfg[3];
  int   bitc = 0;
  int   byte_idx = 0;
  logic [7:0] sh = 8'd0;
  logic pscl = 1'b1;
  logic psda = 1'b1;

  initial forever begin
    @(negedge sys_clk);
    if (pscl && iic_scl && psda && !sda_bus) begin
      mon_q.push_back(START_TOK);
      bitc = 0;
      byte_idx = 0;
      slave_low = 1'b0;
    end else if (pscl && iic_scl && !psda && sda_bus) begin
      mon_q.push_back(STOP_TOK);
      slave_low = 1'b0;
    end else if (!pscl && iic_scl) begin
      if (bitc < 8) sh = {sh[6:0], sda_bus};
      bitc++;
      if (bitc == 9) begin
        mon_q.push_back(int'(sh));
        bitc = 0;
        byte_idx++;
      end
    end else if (pscl && !iic_scl) begin
      if (bitc == 8 && byte_idx < 3) slave_low = !nack_cfg[byte_idx];
      else if (bitc == 0) slave_low = 1'b0;
    end
    pscl = iic_scl;
    psda = sda_bus;
  end

  // Reference model: bytes on the wire and cycle of write_done relative to acceptance.
  function automatic int model_nbytes(input bit n0, input bit n1, input bit n2);
    if (!ACK_CHK) return 3;
    if (n0) return 1;
    if (n1) return 2;
    return 3;
  endfunction

  function automatic int model_latency(input int nb);
    return 1 + (4 + 36 * nb + 4) * QDIV;
  endfunction

  task automatic expect_bus(input logic [23:0] w, input int nb, input string tag);
    int exp_q[$];
    logic [23:0] ww;
    ww = w;
    exp_q.push_back(START_TOK);
    for (int i = 0; i < nb; i++) exp_q.push_back(int'(ww[23 - 8*i -: 8]));
    exp_q.push_back(STOP_TOK);
    check({tag, "_len"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      check($sformatf("%s_tok%0d", tag, i), mon_q[i], exp_q[i]);
  endtask

  task automatic wait_done(input int t0, input bit hold, output int dcyc, output logic err, output bit busy_ok);
    dcyc = -1;
    err = 1'b0;
    busy_ok = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      @(negedge sys_clk);
      if (hold && cyc == t0 + 100) write_data = 24'hFFFFFF;
      if (write_done) begin
        dcyc = cyc;
        err = ack_err;
        if (!busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    if (dcyc < 0) check("done_timeout", 0, 1);
  endtask

  task automatic run_write(input logic [23:0] w, input bit n0, input bit n1, input bit n2,
                           input bit hold, input string tag);
    int t0, dcyc, nb;
    logic err;
    bit busy_ok;
    nack_cfg[0] = n0;
    nack_cfg[1] = n1;
    nack_cfg[2] = n2;
    @(negedge sys_clk);
    mon_q.delete();
    write_data = w;
    write_req = 1'b1;
    t0 = cyc;
    @(negedge sys_clk);
    write_req = 1'b0;
    check({tag, "_busy_start"}, busy, 1'b1);
    nb = model_nbytes(n0, n1, n2);
    wait_done(t0, hold, dcyc, err, busy_ok);
    check({tag, "_done_cycle"}, dcyc - t0, model_latency(nb));
    check({tag, "_ack_err"}, err, ACK_CHK && (n0 || n1 || n2));
    check({tag, "_busy_span"}, busy_ok, 1'b1);
    @(negedge sys_clk);
    check({tag, "_done_single"}, write_done, 1'b0);
    check({tag, "_busy_end"}, busy, 1'b0);
    expect_bus(w, nb, tag);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, dcyc, r;
    logic err;
    bit busy_ok;
    logic [23:0] words[3];
    logic [23:0] w;

    repeat (3) @(negedge sys_clk);
    check("rst_scl", iic_scl, 1'b1);
    check("rst_sda", sda_bus, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", write_done, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    run_write(24'h7800B0, 1'b0, 1'b0, 1'b0, 1'b0, "single");
    run_write(24'h7800B0, 1'b0, 1'b0, 1'b0, 1'b1, "hold");
    run_write(24'h7800B0, 1'b0, 1'b1, 1'b0, 1'b0, "nack_ctrl");

    // Streaming: request held, upstream advances its word on write_done.
    words[0] = 24'h7800B0;
    words[1] = 24'h780005;
    words[2] = 24'h780012;
    nack_cfg[0] = 1'b0;
    nack_cfg[1] = 1'b0;
    nack_cfg[2] = 1'b0;
    @(negedge sys_clk);
    mon_q.delete();
    write_data = words[0];
    write_req = 1'b1;
    t0 = cyc;
    r = t0 + model_latency(3);
    for (int i = 0; i < 3; i++) begin
      wait_done(t0, 1'b0, dcyc, err, busy_ok);
      check($sformatf("stream_done%0d", i), dcyc, r);
      r = r + 1 + model_latency(3);
      if (i < 2) write_data = words[i + 1];
      else write_req = 1'b0;
    end
    @(negedge sys_clk);
    check("stream_idle", busy, 1'b0);
    check("stream_len", mon_q.size(), 15);
    for (int i = 0; i < 3 && mon_q.size() == 15; i++) begin
      w = words[i];
      check($sformatf("stream_s%0d", i), mon_q[5*i], START_TOK);
      check($sformatf("stream_a%0d", i), mon_q[5*i+1], int'(w[23:16]));
      check($sformatf("stream_c%0d", i), mon_q[5*i+2], int'(w[15:8]));
      check($sformatf("stream_d%0d", i), mon_q[5*i+3], int'(w[7:0]));
      check($sformatf("stream_p%0d", i), mon_q[5*i+4], STOP_TOK);
    end

    // Reset mid-byte with the request held; a full transaction follows release.
    @(negedge sys_clk);
    write_data = 24'h7800AF;
    write_req = 1'b1;
    t0 = cyc;
    while (cyc < t0 + 1500) @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    check("midrst_scl", iic_scl, 1'b1);
    check("midrst_sda", sda_bus, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", write_done, 1'b0);
    repeat (3) begin
      @(negedge sys_clk);
      check("midrst_hold_done", write_done, 1'b0);
    end
    mon_q.delete();
    rst_n = 1'b1;
    t0 = cyc;
    @(negedge sys_clk);
    write_req = 1'b0;
    wait_done(t0, 1'b0, dcyc, err, busy_ok);
    check("restart_done_cycle", dcyc - t0, model_latency(3));
    check("restart_busy_span", busy_ok, 1'b1);
    @(negedge sys_clk);
    expect_bus(24'h7800AF, 3, "restart");

    for (int i = 0; i < 6; i++) begin
      w = 24'($urandom);
      r = $urandom_range(0, 3);
      run_write(w, r == 0, r == 1, r == 2, 1'b0, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
